// File: rtl/cc_pkg.sv
// Shared constants and helpers for the colour-correction stage.
// WIDTH/FRAC fix the channel and coefficient formats. ACC_W holds a three-term
// Q8 dot product plus bias and rounding constant without overflow.
// sat_shift drops the fraction with an arithmetic shift and clamps to the channel range.
package cc_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned FRAC  = 8;
    localparam int unsigned ACC_W = 2 * WIDTH + 3;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    // Floor shift; the +0.5 added upstream turns this into round-half-up.
    function automatic logic signed [WIDTH-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC;
        if (sh > ACC_W'(SAT_MAX)) begin
            return WIDTH'(SAT_MAX);
        end else if (sh < ACC_W'(SAT_MIN)) begin
            return WIDTH'(SAT_MIN);
        end
        return sh[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/color_correct_stream_if.sv
// Pixel stream bundle for the colour-correction stage.
// Input side:  in_valid/in_ready handshake, in_r/in_g/in_b signed channels, in_last tag.
// Output side: out_valid/out_ready handshake, out_c0..2 signed channels, out_last tag.
// slave  - the view used by the colour-correction stage itself.
// master - the view used by whatever feeds and drains it.
interface color_correct_stream_if;
    import cc_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_r;
    logic signed [WIDTH-1:0] in_g;
    logic signed [WIDTH-1:0] in_b;
    logic                    in_last;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_c0;
    logic signed [WIDTH-1:0] out_c1;
    logic signed [WIDTH-1:0] out_c2;
    logic                    out_last;

    modport slave (
        input  in_valid, in_r, in_g, in_b, in_last, out_ready,
        output in_ready, out_valid, out_c0, out_c1, out_c2, out_last
    );

    modport master (
        output in_valid, in_r, in_g, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_c0, out_c1, out_c2, out_last
    );

endinterface

// File: rtl/cc_row_mac.sv
// One output row of the colour matrix: c = sat((MA*r + MB*g + MC*b + BIAS<<FRAC + 0.5) >> FRAC).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en_s1/en_s2/en_s3   load enables for the multiply, sum and round/saturate registers
//   in_r/in_g/in_b      signed input channels
//   out_c               signed corrected channel, straight from the final register
// Valid/ready control lives in the parent; this block only moves data when told to.
module cc_row_mac
    import cc_pkg::*;
#(
    parameter logic signed [WIDTH-1:0] MA   = 16'sd0,
    parameter logic signed [WIDTH-1:0] MB   = 16'sd0,
    parameter logic signed [WIDTH-1:0] MC   = 16'sd0,
    parameter logic signed [WIDTH-1:0] BIAS = 16'sd0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_s1,
    input  logic                    en_s2,
    input  logic                    en_s3,
    input  logic signed [WIDTH-1:0] in_r,
    input  logic signed [WIDTH-1:0] in_g,
    input  logic signed [WIDTH-1:0] in_b,
    output logic signed [WIDTH-1:0] out_c
);

    localparam int unsigned PW = 2 * WIDTH;

    // Bias is in output integer units, so it enters the accumulator already scaled.
    localparam logic signed [ACC_W-1:0] BIAS_ACC = ACC_W'(BIAS) <<< FRAC;
    localparam logic signed [ACC_W-1:0] RND      = ACC_W'(1) <<< (FRAC - 1);

    logic signed [PW-1:0]    p0_q, p1_q, p2_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [WIDTH-1:0] c_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_q  <= '0;
            p1_q  <= '0;
            p2_q  <= '0;
            acc_q <= '0;
            c_q   <= '0;
        end else begin
            if (en_s1) begin
                p0_q <= PW'(in_r) * PW'(MA);
                p1_q <= PW'(in_g) * PW'(MB);
                p2_q <= PW'(in_b) * PW'(MC);
            end
            if (en_s2) begin
                acc_q <= ACC_W'(p0_q) + ACC_W'(p1_q) + ACC_W'(p2_q) + BIAS_ACC + RND;
            end
            if (en_s3) begin
                c_q <= sat_shift(acc_q);
            end
        end
    end

    assign out_c = c_q;

endmodule

// File: rtl/color_correct_stream.sv
// Colour-correction stage: fixed 3x3 signed Q8 matrix plus per-channel bias on RGB pixels.
// Three registered stages (multiply, sum, round/saturate) with a combinational ready chain.
// A stage advances when the one after it advances or is empty, so bubbles collapse.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          pixel stream (slave view): in_* accepted, out_* produced, last tag carried
module color_correct_stream
    import cc_pkg::*;
#(
    parameter logic signed [WIDTH-1:0] M00 = 16'sd410,
    parameter logic signed [WIDTH-1:0] M01 = -16'sd90,
    parameter logic signed [WIDTH-1:0] M02 = -16'sd64,
    parameter logic signed [WIDTH-1:0] M10 = -16'sd51,
    parameter logic signed [WIDTH-1:0] M11 = 16'sd358,
    parameter logic signed [WIDTH-1:0] M12 = -16'sd51,
    parameter logic signed [WIDTH-1:0] M20 = -16'sd26,
    parameter logic signed [WIDTH-1:0] M21 = -16'sd102,
    parameter logic signed [WIDTH-1:0] M22 = 16'sd384,
    parameter logic signed [WIDTH-1:0] B0  = 16'sd0,
    parameter logic signed [WIDTH-1:0] B1  = 16'sd0,
    parameter logic signed [WIDTH-1:0] B2  = 16'sd0
) (
    input logic                   clk,
    input logic                   rst_n,
    color_correct_stream_if.slave bus
);

    logic v1_q, v2_q, v3_q;
    logic last1_q, last2_q, last3_q;
    logic adv1, adv2, adv3;
    logic en1, en2, en3;

    always_comb begin
        adv3 = bus.out_ready || !v3_q;
        adv2 = adv3 || !v2_q;
        adv1 = adv2 || !v1_q;
        // Data registers only load when real data moves in, so idle outputs stay put.
        en1  = adv1 && bus.in_valid;
        en2  = adv2 && v1_q;
        en3  = adv3 && v2_q;
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v3_q;
    assign bus.out_last  = last3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            last3_q <= 1'b0;
        end else begin
            if (adv1) v1_q <= bus.in_valid;
            if (adv2) v2_q <= v1_q;
            if (adv3) v3_q <= v2_q;
            if (en1)  last1_q <= bus.in_last;
            if (en2)  last2_q <= last1_q;
            if (en3)  last3_q <= last2_q;
        end
    end

    cc_row_mac #(.MA(M00), .MB(M01), .MC(M02), .BIAS(B0)) u_row0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_s1 (en1),
        .en_s2 (en2),
        .en_s3 (en3),
        .in_r  (bus.in_r),
        .in_g  (bus.in_g),
        .in_b  (bus.in_b),
        .out_c (bus.out_c0)
    );

    cc_row_mac #(.MA(M10), .MB(M11), .MC(M12), .BIAS(B1)) u_row1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_s1 (en1),
        .en_s2 (en2),
        .en_s3 (en3),
        .in_r  (bus.in_r),
        .in_g  (bus.in_g),
        .in_b  (bus.in_b),
        .out_c (bus.out_c1)
    );

    cc_row_mac #(.MA(M20), .MB(M21), .MC(M22), .BIAS(B2)) u_row2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_s1 (en1),
        .en_s2 (en2),
        .en_s3 (en3),
        .in_r  (bus.in_r),
        .in_g  (bus.in_g),
        .in_b  (bus.in_b),
        .out_c (bus.out_c2)
    );

endmodule

// File: tb/tb_color_correct_stream.sv
// Scoreboard bench for color_correct_stream: accepted pixels push the model's answer,
// a forked monitor pops and compares whenever the stage presents a pixel.
module tb_color_correct_stream;

    logic clk;
    logic rst_n;
    int   cyc;

    color_correct_stream_if bus ();

    color_correct_stream u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c0;
        int c1;
        int c2;
        bit last;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   mode;       // 0: out_ready high, 1: out_ready low, 2: random
    bit   lat_strict; // check fixed latency on every output

    // Matrix rows and bias, written out as plain numbers.
    int mtx [3][3] = '{'{410, -90, -64}, '{-51, 358, -51}, '{-26, -102, 384}};
    int bias[3]    = '{0, 0, 0};

    // Reference: exact dot product, +0.5, floor divide by 256, clamp to 16-bit signed.
    function automatic int model_ch(input int r, input int g, input int b, input int k);
        longint s, q;
        s = longint'(r) * mtx[k][0] + longint'(g) * mtx[k][1] + longint'(b) * mtx[k][2]
            + longint'(bias[k]) * 256 + 128;
        q = s / 256;
        if ((s % 256) != 0 && s < 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    function automatic int rnd_ch();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 2047)) - 1024;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Present one pixel for the coming edge; record it if the stage will take it.
    task automatic offer(input int r, input int g, input int b, input bit last,
                         input int e0, input int e1, input int e2, output bit acc);
        exp_t e;
        @(negedge clk);
        bus.in_r     = 16'(r);
        bus.in_g     = 16'(g);
        bus.in_b     = 16'(b);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        #1;
        acc = bus.in_ready;
        if (acc) begin
            e.c0 = e0; e.c1 = e1; e.c2 = e2; e.last = last; e.acc_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic send_exp(input int r, input int g, input int b, input bit last,
                            input int e0, input int e1, input int e2);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) offer(r, g, b, last, e0, e1, e2, acc);
        if (!acc) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input int r, input int g, input int b, input bit last);
        send_exp(r, g, b, last, model_ch(r, g, b, 0), model_ch(r, g, b, 1),
                 model_ch(r, g, b, 2));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_r     = 16'(rnd_ch());
            bus.in_g     = 16'(rnd_ch());
            bus.in_b     = 16'(rnd_ch());
            bus.in_last  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain(input string name, input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clk);
        #2;
        chk(name, sb.size(), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pr[5], pg[5], pb[5];
        bit pl[5];
        int n;
        bit acc;

        checks = 0; errors = 0; mode = 0; lat_strict = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_r = '0; bus.in_g = '0; bus.in_b = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b1;

        fork
            // Monitor: out_ready policy at each negedge, then check what will transfer.
            forever begin
                exp_t e;
                @(negedge clk);
                case (mode)
                    0:       bus.out_ready = 1'b1;
                    1:       bus.out_ready = 1'b0;
                    default: bus.out_ready = 1'($urandom_range(0, 1));
                endcase
                #1;
                if (rst_n && bus.out_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pixel", 1, 0);
                    end else begin
                        e = sb[0];
                        checks++;
                        if (int'(bus.out_c0) != e.c0 || int'(bus.out_c1) != e.c1 ||
                            int'(bus.out_c2) != e.c2 || bus.out_last != e.last) begin
                            errors++;
                            $display("FAIL pixel: got (%0d,%0d,%0d,last=%0b) want (%0d,%0d,%0d,last=%0b)",
                                     bus.out_c0, bus.out_c1, bus.out_c2, bus.out_last,
                                     e.c0, e.c1, e.c2, e.last);
                        end
                        if (bus.out_ready) begin
                            // Presented in cycle k, visible from cycle k+3.
                            if (lat_strict) chk("latency", cyc - e.acc_cyc, 3);
                            void'(sb.pop_front());
                        end
                    end
                end
            end
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_c0", bus.out_c0, 0);
        chk("rst_out_c1", bus.out_c1, 0);
        chk("rst_out_c2", bus.out_c2, 0);
        chk("rst_out_last", bus.out_last, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("in_ready_after_reset", bus.in_ready, 1);

        // Directed vectors with hand-computed answers, back to back, fixed latency.
        lat_strict = 1'b1;
        send_exp(256, 256, 256, 1'b1, 256, 256, 256);
        send_exp(1000, 0, 0, 1'b0, 1602, -199, -102);
        send_exp(32767, -32768, -32768, 1'b1, 32767, -32768, -32768);
        send_exp(-1000, 0, 0, 1'b0, -1602, 199, 102);
        send(-1000, 500, 20000, 1'b1);
        drain("drain_directed", 50);
        lat_strict = 1'b0;

        // Backpressure: five pixels offered into a stalled stage.
        mode = 1;
        idle(2);
        for (int i = 0; i < 5; i++) begin
            pr[i] = rnd_ch(); pg[i] = rnd_ch(); pb[i] = rnd_ch(); pl[i] = 1'(i & 1);
        end
        n = 0;
        for (int k = 0; k < 8; k++) begin
            offer(pr[n], pg[n], pb[n], pl[n], model_ch(pr[n], pg[n], pb[n], 0),
                  model_ch(pr[n], pg[n], pb[n], 1), model_ch(pr[n], pg[n], pb[n], 2), acc);
            if (acc) n++;
        end
        chk("bp_accepted", n, 3);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        mode = 0;
        while (n < 5) begin
            send(pr[n], pg[n], pb[n], pl[n]);
            n++;
        end
        drain("drain_backpressure", 12);

        // Random traffic with random backpressure.
        mode = 2;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            send(rnd_ch(), rnd_ch(), rnd_ch(), 1'($urandom_range(0, 1)));
        end
        mode = 0;
        drain("drain_random", 50);

        // Reset with three pixels in flight.
        mode = 1;
        idle(2);
        send(1000, 0, 0, 1'b1);
        send(2000, 100, -50, 1'b0);
        send(-300, 4000, 700, 1'b1);
        idle(1);
        chk("pre_rst_out_valid", bus.out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_c0", bus.out_c0, 0);
        chk("midrst_out_c1", bus.out_c1, 0);
        chk("midrst_out_c2", bus.out_c2, 0);
        chk("midrst_out_last", bus.out_last, 0);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        mode = 0;
        idle(10);
        #1;
        chk("in_ready_after_midrst", bus.in_ready, 1);
        chk("no_stale_valid", bus.out_valid, 0);
        send(-500, 250, 12000, 1'b1);
        drain("drain_after_reset", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
